imm_extend_pipe: RTL and testbench
==================================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, immediate field width.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, extended result width; legal only when OUT_WIDTH >= IN_WIDTH+2.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, producer offers an immediate.
REQ-006 SHALL have port in_ready, output, 1, block accepts the offer this cycle.
REQ-007 SHALL have port in_imm, input, IN_WIDTH, raw immediate field.
REQ-008 SHALL have port in_mode, input, 2, extension mode.
REQ-009 SHALL have port out_valid, output, 1, out_data holds a result.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the result this cycle.
REQ-011 SHALL have port out_data, output, OUT_WIDTH, extended result.

Function
REQ-012 Transfer SHALL occur on each side only when valid and ready are both high at a rising edge.
REQ-013 Mode 0 (ZERO) SHALL output in_imm zero-extended to OUT_WIDTH.
REQ-014 Mode 1 (SIGN) SHALL replicate bit IN_WIDTH-1 into all upper bits.
REQ-015 Mode 2 (UPPER) SHALL output in_imm in bits OUT_WIDTH-1 : OUT_WIDTH-IN_WIDTH; lower bits zero.
REQ-016 Mode 3 (BRANCH) SHALL output the sign-extended value shifted left 2, truncated to OUT_WIDTH; bits 1:0 zero.
REQ-017 Mode and data SHALL be captured together; a later change of in_mode SHALL NOT alter a captured result.
REQ-018 Latency SHALL be exactly 1 cycle from input transfer to out_valid high when the output stage is empty.
REQ-019 Results SHALL leave in acceptance order, with none lost or duplicated.
REQ-020 out_data SHALL hold stable while out_valid is high and out_ready is low.
REQ-021 Simultaneous input and output transfers SHALL be sustained at 1 result per cycle.

Reset
REQ-022 While reset is high: out_valid=0, out_data=0, in_ready=0, any skid entry discarded, state EMPTY.
REQ-023 The first cycle after reset deasserts SHALL present in_ready=1.
REQ-024 A reset asserted mid-transfer SHALL discard all held results without emitting them.

Configuration
REQ-025 Macro IMM_EXTEND_PIPE_SKID_EN SHALL select the buffering scheme.
REQ-026 With the macro defined, the block SHALL have a 2-entry buffer (output register plus skid register).
  - States: EMPTY, ONE, FULL.
  - in_ready is registered: high in EMPTY and ONE, low in FULL.
  - EMPTY->ONE on input transfer.
  - ONE->FULL on input transfer without output transfer.
  - ONE->EMPTY on output transfer without input transfer.
  - FULL->ONE on output transfer; the skid entry moves to the output register.
REQ-027 With the macro undefined, the block SHALL have a single output register with combinational in_ready = !out_valid || out_ready; states EMPTY and ONE only.

Structure
REQ-028 Package imm_ext_pkg SHALL hold:
  - mode constants MODE_ZERO=0, MODE_SIGN=1, MODE_UPPER=2, MODE_BRANCH=3;
  - the buffer state enumeration.
REQ-029 Combinational extension SHALL be implemented in sub-module imm_ext_core (inputs imm and mode; output result), instantiated once at the input side.

Verification (IN_WIDTH=16, OUT_WIDTH=32, out_ready=1 unless stated)
REQ-030 SIGN 0x8000 -> 0xFFFF8000; SIGN 0x7FFF -> 0x00007FFF; both one cycle after transfer.
REQ-031 ZERO 0xF000 -> 0x0000F000; UPPER 0x1234 -> 0x12340000.
REQ-032 BRANCH 0xFFFF -> 0xFFFFFFFC; BRANCH 0x0004 -> 0x00000010.
REQ-033 Send 0x0001, 0x0002, 0x0003 (SIGN) back-to-back with out_ready low for 3 cycles:
  - SKID_EN: in_ready falls after 2 accepts (FULL); the third is held at input.
  - No SKID_EN: in_ready falls after 1 accept.
  - Either build, after release: outputs 0x00000001, 0x00000002, 0x00000003 in order with out_data stable while stalled.
REQ-034 Stream 8 values with in_valid=out_ready=1 every cycle -> 8 outputs on 8 consecutive cycles.
REQ-035 Assert reset for 1 cycle while FULL -> out_valid=0 and out_data=0 next cycle, in_ready=1 the cycle after reset deasserts, held data never emitted.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared constants for the immediate-extension pipeline.
//   - MODE_* : encodings of the 2-bit extension mode input.
//   - buf_state_t / ST_* : occupancy of the output buffer (EMPTY, ONE, FULL).
package imm_ext_pkg;

    localparam logic [1:0] MODE_ZERO   = 2'd0;
    localparam logic [1:0] MODE_SIGN   = 2'd1;
    localparam logic [1:0] MODE_UPPER  = 2'd2;
    localparam logic [1:0] MODE_BRANCH = 2'd3;

    // Buffer occupancy; FULL is only reachable when the skid register exists.
    typedef logic [1:0] buf_state_t;
    localparam buf_state_t ST_EMPTY = 2'd0;
    localparam buf_state_t ST_ONE   = 2'd1;
    localparam buf_state_t ST_FULL  = 2'd2;

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extension.
// Ports:
//   imm    [IN_WIDTH-1:0]  raw immediate field
//   mode   [1:0]           ZERO / SIGN / UPPER / BRANCH
//   result [OUT_WIDTH-1:0] extended value
// OUT_WIDTH must be at least IN_WIDTH+2 so the BRANCH shift never drops sign bits.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic [IN_WIDTH-1:0]  imm,
    input  logic [1:0]           mode,
    output logic [OUT_WIDTH-1:0] result
);

    localparam int PAD = OUT_WIDTH - IN_WIDTH;

    logic [OUT_WIDTH-1:0] sext;

    always_comb begin
        sext   = {{PAD{imm[IN_WIDTH-1]}}, imm};
        result = '0;
        case (mode)
            MODE_ZERO:  result = {{PAD{1'b0}}, imm};
            MODE_SIGN:  result = sext;
            MODE_UPPER: result = {imm, {PAD{1'b0}}};
            default:    result = {sext[OUT_WIDTH-3:0], 2'b00};  // BRANCH: word offset
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: valid/ready pipeline stage that extends an immediate field.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_imm, in_mode captured on transfer
//   out_valid/out_ready   output handshake; out_data holds the extended result
// Configuration macro IMM_EXTEND_PIPE_SKID_EN:
//   defined   - output register plus skid register, registered in_ready
//   undefined - single output register, in_ready = !out_valid || out_ready
// Extension happens at the input side, so in_mode is never needed after capture.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_imm,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data
);

    logic [OUT_WIDTH-1:0] ext_data;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    buf_state_t           state_q, state_d;
    logic                 in_fire, out_fire;

    imm_ext_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .imm    (in_imm),
        .mode   (in_mode),
        .result (ext_data)
    );

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_data_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

`ifdef IMM_EXTEND_PIPE_SKID_EN
    logic [OUT_WIDTH-1:0] skid_q, skid_d;
    logic                 in_ready_q;

    // Registered ready resets high so the first post-reset cycle accepts; the
    // reset term only forces it low while reset is held.
    assign in_ready = in_ready_q && !reset;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        skid_d     = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    out_data_d = ext_data;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    out_data_d = ext_data;
                end else if (in_fire) begin
                    skid_d  = ext_data;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the output side can move.
                if (out_fire) begin
                    out_data_d = skid_q;
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end
`else
    assign in_ready = !reset && (!out_valid || out_ready);

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        if (in_fire) begin
            out_data_d = ext_data;
            state_d    = ST_ONE;
        end else if (out_fire) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
        end
    end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe (IN_WIDTH=16, OUT_WIDTH=32). A queue holds the
// results the DUT must currently be holding; it is checked every cycle at the
// falling edge and updated with the transfers that the next rising edge makes.
module tb_imm_extend_pipe;

    localparam int IN_WIDTH  = 16;
    localparam int OUT_WIDTH = 32;
`ifdef IMM_EXTEND_PIPE_SKID_EN
    localparam bit SKID          = 1'b1;
    localparam int STALL_ACCEPTS = 2;
`else
    localparam bit SKID          = 1'b0;
    localparam int STALL_ACCEPTS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] out_log[$];
    int          acc_count = 0;
    bit          pend_in_fire = 1'b0;
    bit          started = 1'b0;
    bit          was_reset = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    imm_extend_pipe #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Reference: treat the immediate as a number and apply the mode rule.
    function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] mode);
        longint u;
        longint s;
        u = longint'(imm);
        s = (u >= 32768) ? u - 65536 : u;
        case (mode)
            2'd0:    return 32'(u);
            2'd1:    return 32'(s);
            2'd2:    return 32'(u * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        bit inf;
        bit outf;
        if (reset) begin
            started = 1'b1;
            check("ready_in_reset", 32'(in_ready), 32'd0);
            exp_q.delete();
            pend_in_fire = 1'b0;
            was_reset    = 1'b1;
            prev_stall   = 1'b0;
        end else if (started) begin
            if (was_reset) begin
                check("valid_after_reset", 32'(out_valid), 32'd0);
                check("data_after_reset", out_data, 32'd0);
            end
            was_reset = 1'b0;
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
            if (prev_stall) check("stall_stable", out_data, prev_data);
            check("in_ready", 32'(in_ready),
                  SKID ? 32'(exp_q.size() < 2) : 32'(exp_q.size() == 0 || out_ready));
            inf  = in_valid && in_ready;
            outf = out_valid && out_ready;
            if (outf) begin
                out_log.push_back(out_data);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (inf) begin
                exp_q.push_back(model_ext(in_imm, in_mode));
                acc_count++;
            end
            pend_in_fire = inf;
            prev_stall   = out_valid && !out_ready;
            prev_data    = out_data;
        end
    end

    task automatic send_check(input logic [15:0] imm, input logic [1:0] mode,
                              input logic [31:0] req, input string name);
        in_valid  = 1'b1;
        in_imm    = imm;
        in_mode   = mode;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_mode  = ~mode;  // must not disturb the captured result
        #1;
        check("direct_valid", 32'(out_valid), 32'd1);
        check(name, out_data, req);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] vals[3];
        int          idx;
        int          a0;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("ready_first_cycle", 32'(in_ready), 32'd1);

        send_check(16'h8000, 2'd1, 32'hFFFF8000, "sign_neg");
        send_check(16'h7FFF, 2'd1, 32'h00007FFF, "sign_pos");
        send_check(16'hF000, 2'd0, 32'h0000F000, "zero");
        send_check(16'h1234, 2'd2, 32'h12340000, "upper");
        send_check(16'hFFFF, 2'd3, 32'hFFFFFFFC, "branch_neg");
        send_check(16'h0004, 2'd3, 32'h00000010, "branch_pos");

        // Stall with three back-to-back offers.
        vals = '{16'h0001, 16'h0002, 16'h0003};
        out_log.delete();
        idx       = 0;
        a0        = acc_count;
        out_ready = 1'b0;
        in_mode   = 2'd1;
        in_valid  = 1'b1;
        in_imm    = vals[0];
        repeat (3) begin
            tick();
            if (pend_in_fire && idx < 3) begin
                idx++;
                if (idx < 3) in_imm = vals[idx];
                else in_valid = 1'b0;
            end
        end
        check("stall_accepts", 32'(acc_count - a0), 32'(STALL_ACCEPTS));
        check("stall_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (idx < 3 || exp_q.size() != 0); k++) begin
            tick();
            if (pend_in_fire && idx < 3) begin
                idx++;
                if (idx < 3) in_imm = vals[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("drain_accepts", 32'(idx), 32'd3);
        check("order_count", 32'(out_log.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < out_log.size()) check("order_value", out_log[k], 32'(k + 1));
        end

        // Full-rate streaming.
        out_log.delete();
        a0 = acc_count;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_imm   = 16'($urandom);
            in_mode  = 2'($urandom_range(0, 3));
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("stream_accepts", 32'(acc_count - a0), 32'd8);
        check("stream_outputs", 32'(out_log.size()), 32'd8);

        // Fill the buffer, then reset over it.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (3) begin
            in_imm  = 16'($urandom);
            in_mode = 2'($urandom_range(0, 3));
            tick();
        end
        in_valid = 1'b0;
        check("full_before_reset", 32'(in_ready), 32'd0);
        reset = 1'b1;
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);
        out_log.delete();
        out_ready = 1'b1;
        repeat (4) tick();
        check("no_stale_output", 32'(out_log.size()), 32'd0);

        // Random traffic on both sides.
        repeat (400) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom_range(0, 3));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
